// File: rtl/mem_stage_resp.sv
// MEM pipeline stage with split request/response data memory: waits for data_ok,
// buffers data under WB back-pressure, discards responses of flushed loads, aligns/extends loads.
module mem_stage_resp #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned LDT_W    = 7,
    parameter int unsigned ES_BUS_W = LDT_W + 1 + 1 + 5 + DATA_W + 32,
    parameter int unsigned WS_BUS_W = 1 + 5 + DATA_W + 32,
    parameter int unsigned CNCL_W   = 2
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                es_to_ms_valid,
    input  logic [ES_BUS_W-1:0] es_to_ms_bus,
    input  logic                es_mem_req,
    output logic                ms_allowin,
    output logic                ms_to_ws_valid,
    output logic [WS_BUS_W-1:0] ms_to_ws_bus,
    input  logic                ws_allowin,
    input  logic                data_sram_data_ok,
    input  logic [DATA_W-1:0]   data_sram_rdata,
    input  logic                flush,
    output logic                ms_valid_o
);

    localparam int unsigned OFF_W    = (DATA_W == 64) ? 3 : 2;
    localparam int unsigned PC_LSB   = 0;
    localparam int unsigned ALU_LSB  = 32;
    localparam int unsigned DEST_LSB = ALU_LSB + DATA_W;
    localparam int unsigned GRWE_BIT = DEST_LSB + 5;
    localparam int unsigned RFM_BIT  = GRWE_BIT + 1;
    localparam int unsigned LDT_LSB  = RFM_BIT + 1;

    // one-hot load type, ld_b in the MSB down to ld_d in bit 0
    localparam int unsigned LD_B  = 6;
    localparam int unsigned LD_BU = 5;
    localparam int unsigned LD_H  = 4;
    localparam int unsigned LD_HU = 3;
    localparam int unsigned LD_W  = 2;
    localparam int unsigned LD_WU = 1;
    localparam int unsigned LD_D  = 0;

    localparam logic [CNCL_W-1:0] CNCL_MAX = {CNCL_W{1'b1}};

    if (DATA_W != 32 && DATA_W != 64) begin : g_bad_width
        $error("mem_stage_resp: DATA_W must be 32 or 64");
    end

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2,
        S_READY = 2'd3
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [ES_BUS_W-1:0] bus_r;
    logic [DATA_W-1:0]   buf_r;
    logic [CNCL_W-1:0]   cncl_cnt;

    logic                ms_valid;
    logic                ms_ready_go;
    logic                latch;
    logic                cncl_inc;
    logic                cncl_dec;
    logic                buf_cap;

    logic [LDT_W-1:0]    ld_type;
    logic                res_from_mem;
    logic                gr_we;
    logic [4:0]          dest;
    logic [DATA_W-1:0]   alu_result;
    logic [31:0]         pc;
    logic [OFF_W-1:0]    byte_off;
    logic [DATA_W-1:0]   mem_data;
    logic [DATA_W-1:0]   shifted;
    logic [DATA_W-1:0]   load_data;
    logic [DATA_W-1:0]   final_result;

    assign ms_valid   = (state != S_EMPTY);
    assign ms_valid_o = ms_valid;

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= S_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = S_EMPTY;
        end else if (latch) begin
            state_nxt = es_mem_req ? S_WAIT : S_READY;
        end else begin
            case (state)
                S_WAIT: begin
                    if (data_sram_data_ok && (cncl_cnt == '0)) begin
                        state_nxt = ws_allowin ? S_EMPTY : S_HOLD;
                    end
                end
                S_HOLD, S_READY: begin
                    if (ws_allowin) begin
                        state_nxt = S_EMPTY;
                    end
                end
                default: state_nxt = state;
            endcase
        end
    end

    // Handshake and discard-counter control
    always_comb begin
        ms_ready_go = 1'b0;
        case (state)
            S_WAIT:          ms_ready_go = data_sram_data_ok && (cncl_cnt == '0);
            S_HOLD, S_READY: ms_ready_go = 1'b1;
            default:         ms_ready_go = 1'b0;
        endcase
        ms_allowin     = !ms_valid || (ms_ready_go && ws_allowin);
        ms_to_ws_valid = ms_valid && ms_ready_go && !flush;
        latch          = es_to_ms_valid && ms_allowin && !flush;
        // a flushed WAIT still owes a response unless it is consumed this very cycle
        cncl_inc       = flush && (state == S_WAIT)
                         && !(data_sram_data_ok && (cncl_cnt == '0));
        cncl_dec       = data_sram_data_ok && (cncl_cnt != '0);
        buf_cap        = (state == S_WAIT) && data_sram_data_ok && (cncl_cnt == '0)
                         && !ws_allowin && !flush;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bus_r <= '0;
        end else if (latch) begin
            bus_r <= es_to_ms_bus;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            buf_r <= '0;
        end else if (buf_cap) begin
            buf_r <= data_sram_rdata;
        end
    end

    // Outstanding responses owned by flushed instructions
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cncl_cnt <= '0;
        end else if (cncl_inc && !cncl_dec && (cncl_cnt != CNCL_MAX)) begin
            cncl_cnt <= cncl_cnt + CNCL_W'(1);
        end else if (cncl_dec && !cncl_inc) begin
            cncl_cnt <= cncl_cnt - CNCL_W'(1);
        end
    end

    cncl_sat_a: assert property (@(posedge clk) disable iff (!resetn) cncl_cnt != CNCL_MAX)
        else $error("mem_stage_resp: discard counter saturated");

    assign ld_type      = bus_r[LDT_LSB +: LDT_W];
    assign res_from_mem = bus_r[RFM_BIT];
    assign gr_we        = bus_r[GRWE_BIT];
    assign dest         = bus_r[DEST_LSB +: 5];
    assign alu_result   = bus_r[ALU_LSB +: DATA_W];
    assign pc           = bus_r[PC_LSB +: 32];
    assign byte_off     = alu_result[OFF_W-1:0];

    // Load alignment and extension
    always_comb begin
        mem_data = (state == S_HOLD) ? buf_r : data_sram_rdata;
        shifted  = mem_data >> {byte_off, 3'b000};
        if (ld_type[LD_B]) begin
            load_data = DATA_W'($signed(shifted[7:0]));
        end else if (ld_type[LD_BU]) begin
            load_data = DATA_W'(shifted[7:0]);
        end else if (ld_type[LD_H]) begin
            load_data = DATA_W'($signed(shifted[15:0]));
        end else if (ld_type[LD_HU]) begin
            load_data = DATA_W'(shifted[15:0]);
        end else if (ld_type[LD_W]) begin
            load_data = DATA_W'($signed(shifted[31:0]));
        end else if (ld_type[LD_WU]) begin
            load_data = DATA_W'(shifted[31:0]);
        end else if (ld_type[LD_D]) begin
            load_data = shifted;
        end else begin
            load_data = shifted;
        end
        final_result = res_from_mem ? load_data : alu_result;
    end

    assign ms_to_ws_bus = {gr_we, dest, final_result, pc};

endmodule

// File: tb/tb_mem_stage_resp.sv
// Directed bench for mem_stage_resp: 32-bit and 64-bit instances, hand-computed results.
module tb_mem_stage_resp;

    localparam int unsigned LDT_W  = 7;
    localparam int unsigned ES32_W = LDT_W + 7 + 32 + 32;
    localparam int unsigned WS32_W = 6 + 32 + 32;
    localparam int unsigned ES64_W = LDT_W + 7 + 64 + 32;
    localparam int unsigned WS64_W = 6 + 64 + 32;

    localparam logic [6:0] T_B    = 7'b1000000;
    localparam logic [6:0] T_BU   = 7'b0100000;
    localparam logic [6:0] T_HU   = 7'b0001000;
    localparam logic [6:0] T_W    = 7'b0000100;
    localparam logic [6:0] T_WU   = 7'b0000010;
    localparam logic [6:0] T_D    = 7'b0000001;
    localparam logic [6:0] T_NONE = 7'b0000000;

    logic clk;
    logic resetn;

    logic              a_es_valid, a_req, a_allowin, a_ws_valid, a_wsa, a_ok, a_flush, a_valid_o;
    logic [ES32_W-1:0] a_es_bus;
    logic [WS32_W-1:0] a_ws_bus;
    logic [31:0]       a_rdata;

    logic              b_es_valid, b_req, b_allowin, b_ws_valid, b_wsa, b_ok, b_flush, b_valid_o;
    logic [ES64_W-1:0] b_es_bus;
    logic [WS64_W-1:0] b_ws_bus;
    logic [63:0]       b_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    mem_stage_resp #(.DATA_W(32)) u32 (
        .clk(clk), .resetn(resetn),
        .es_to_ms_valid(a_es_valid), .es_to_ms_bus(a_es_bus), .es_mem_req(a_req),
        .ms_allowin(a_allowin), .ms_to_ws_valid(a_ws_valid), .ms_to_ws_bus(a_ws_bus),
        .ws_allowin(a_wsa), .data_sram_data_ok(a_ok), .data_sram_rdata(a_rdata),
        .flush(a_flush), .ms_valid_o(a_valid_o)
    );

    mem_stage_resp #(.DATA_W(64)) u64 (
        .clk(clk), .resetn(resetn),
        .es_to_ms_valid(b_es_valid), .es_to_ms_bus(b_es_bus), .es_mem_req(b_req),
        .ms_allowin(b_allowin), .ms_to_ws_valid(b_ws_valid), .ms_to_ws_bus(b_ws_bus),
        .ws_allowin(b_wsa), .data_sram_data_ok(b_ok), .data_sram_rdata(b_rdata),
        .flush(b_flush), .ms_valid_o(b_valid_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [ES32_W-1:0] mk32(input logic [6:0] ldt, input logic rfm,
            input logic we, input logic [4:0] dst, input logic [31:0] alu, input logic [31:0] pc);
        return {ldt, rfm, we, dst, alu, pc};
    endfunction

    function automatic logic [ES64_W-1:0] mk64(input logic [6:0] ldt, input logic rfm,
            input logic we, input logic [4:0] dst, input logic [63:0] alu, input logic [31:0] pc);
        return {ldt, rfm, we, dst, alu, pc};
    endfunction

    task automatic a_drive(input logic v, input logic [ES32_W-1:0] bus, input logic req,
            input logic ok, input logic [31:0] rd, input logic wsa, input logic fl);
        a_es_valid = v; a_es_bus = bus; a_req = req;
        a_ok = ok; a_rdata = rd; a_wsa = wsa; a_flush = fl;
    endtask

    task automatic b_drive(input logic v, input logic [ES64_W-1:0] bus, input logic req,
            input logic ok, input logic [63:0] rd, input logic wsa, input logic fl);
        b_es_valid = v; b_es_bus = bus; b_req = req;
        b_ok = ok; b_rdata = rd; b_wsa = wsa; b_flush = fl;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        resetn = 1'b0;
        a_drive(0, '0, 0, 0, '0, 1, 0);
        b_drive(0, '0, 0, 0, '0, 1, 0);
        step(); step();
        #1;
        check("rst_valid", 64'(a_ws_valid), 64'd0);
        check("rst_allowin", 64'(a_allowin), 64'd1);
        check("rst_bus", 64'(a_ws_bus), 64'd0);
        check("rst_valid_o", 64'(a_valid_o), 64'd0);
        resetn = 1'b1;

        // ld_b with 3-cycle response, next ld_bu accepted in the response cycle
        step(); a_drive(1, mk32(T_B, 1, 1, 5'd3, 32'h1003, 32'h1c00_0000), 1, 0, '0, 1, 0); #1;
        check("t1_accept_allowin", 64'(a_allowin), 64'd1);
        step(); a_drive(0, '0, 0, 0, '0, 1, 0); #1;
        check("t1_c1_valid", 64'(a_ws_valid), 64'd0);
        check("t1_c1_allowin", 64'(a_allowin), 64'd0);
        step(); #1;
        check("t1_c2_valid", 64'(a_ws_valid), 64'd0);
        check("t1_c2_allowin", 64'(a_allowin), 64'd0);
        step(); a_drive(1, mk32(T_BU, 1, 1, 5'd4, 32'h2001, 32'h1c00_0004), 1, 1, 32'h80FF_1234, 1, 0); #1;
        check("t1_c3_valid", 64'(a_ws_valid), 64'd1);
        check("t1_c3_final", 64'(a_ws_bus[63:32]), 64'hFFFF_FF80);
        check("t1_c3_dest", 64'(a_ws_bus[68:64]), 64'd3);
        check("t1_c3_allowin", 64'(a_allowin), 64'd1);
        step(); a_drive(0, '0, 0, 0, '0, 1, 0); #1;
        check("t1_bu_wait_valid", 64'(a_ws_valid), 64'd0);
        step(); a_drive(0, '0, 0, 1, 32'h0000_AB00, 1, 0); #1;
        check("t1_bu_valid", 64'(a_ws_valid), 64'd1);
        check("t1_bu_final", 64'(a_ws_bus[63:32]), 64'h0000_00AB);

        // ld_hu held while WB stalls
        step(); a_drive(1, mk32(T_HU, 1, 1, 5'd6, 32'h2002, 32'h1c00_0008), 1, 0, '0, 1, 0); #1;
        step(); a_drive(0, '0, 0, 1, 32'hBEEF_0001, 0, 0); #1;
        check("t2_h0_valid", 64'(a_ws_valid), 64'd1);
        check("t2_h0_final", 64'(a_ws_bus[63:32]), 64'h0000_BEEF);
        check("t2_h0_allowin", 64'(a_allowin), 64'd0);
        step(); a_drive(0, '0, 0, 0, 32'h1234_5678, 0, 0); #1;
        check("t2_h1_valid", 64'(a_ws_valid), 64'd1);
        check("t2_h1_final", 64'(a_ws_bus[63:32]), 64'h0000_BEEF);
        step(); a_drive(0, '0, 0, 0, 32'h1234_5678, 1, 0); #1;
        check("t2_h2_valid", 64'(a_ws_valid), 64'd1);
        check("t2_h2_final", 64'(a_ws_bus[63:32]), 64'h0000_BEEF);
        check("t2_h2_allowin", 64'(a_allowin), 64'd1);
        step(); a_drive(0, '0, 0, 0, '0, 1, 0); #1;
        check("t2_done_valid", 64'(a_ws_valid), 64'd0);

        // flush in WAIT, stale response discarded
        step(); a_drive(1, mk32(T_W, 1, 1, 5'd7, 32'h3000, 32'h1c00_000c), 1, 0, '0, 1, 0); #1;
        step(); a_drive(0, '0, 0, 0, '0, 1, 1); #1;
        check("t3_flush_valid", 64'(a_ws_valid), 64'd0);
        check("t3_flush_valid_o", 64'(a_valid_o), 64'd1);
        step(); a_drive(1, mk32(T_W, 1, 1, 5'd8, 32'h3004, 32'h1c00_0010), 1, 0, '0, 1, 0); #1;
        check("t3_cncl_one", 64'(u32.cncl_cnt), 64'd1);
        check("t3_accept_allowin", 64'(a_allowin), 64'd1);
        step(); a_drive(0, '0, 0, 1, 32'h0000_DEAD, 1, 0); #1;
        check("t3_discard_valid", 64'(a_ws_valid), 64'd0);
        step(); a_drive(0, '0, 0, 1, 32'h0000_1234, 1, 0); #1;
        check("t3_cncl_zero", 64'(u32.cncl_cnt), 64'd0);
        check("t3_wb_valid", 64'(a_ws_valid), 64'd1);
        check("t3_wb_final", 64'(a_ws_bus[63:32]), 64'h0000_1234);

        // non-memory instruction and a store
        step(); a_drive(1, mk32(T_NONE, 0, 1, 5'd5, 32'h55, 32'h1c00_0014), 0, 0, '0, 1, 0); #1;
        step(); a_drive(0, '0, 0, 0, '0, 1, 0); #1;
        check("t4_add_valid", 64'(a_ws_valid), 64'd1);
        check("t4_add_final", 64'(a_ws_bus[63:32]), 64'h55);
        check("t4_add_we_dest", 64'(a_ws_bus[69:64]), 64'h25);
        check("t4_add_pc", 64'(a_ws_bus[31:0]), 64'h1c00_0014);
        step(); a_drive(1, mk32(T_NONE, 0, 0, 5'd0, 32'h7000, 32'h1c00_0018), 1, 0, '0, 1, 0); #1;
        step(); a_drive(0, '0, 0, 0, '0, 1, 0); #1;
        check("t4_st_wait_valid", 64'(a_ws_valid), 64'd0);
        step(); a_drive(0, '0, 0, 1, 32'hFFFF_FFFF, 1, 0); #1;
        check("t4_st_valid", 64'(a_ws_valid), 64'd1);
        check("t4_st_final", 64'(a_ws_bus[63:32]), 64'h7000);
        check("t4_st_we", 64'(a_ws_bus[69]), 64'd0);

        // 64-bit datapath
        step(); a_drive(0, '0, 0, 0, '0, 1, 0);
        b_drive(1, mk64(T_W, 1, 1, 5'd9, 64'h4004, 32'h1c00_0020), 1, 0, '0, 1, 0); #1;
        step(); b_drive(0, '0, 0, 1, 64'h8000_0001_0000_0000, 1, 0); #1;
        check("t5_w_valid", 64'(b_ws_valid), 64'd1);
        check("t5_w_final", b_ws_bus[95:32], 64'hFFFF_FFFF_8000_0001);
        step(); b_drive(1, mk64(T_WU, 1, 1, 5'd9, 64'h4004, 32'h1c00_0024), 1, 0, '0, 1, 0); #1;
        step(); b_drive(0, '0, 0, 1, 64'h8000_0001_0000_0000, 1, 0); #1;
        check("t5_wu_final", b_ws_bus[95:32], 64'h0000_0000_8000_0001);
        step(); b_drive(1, mk64(T_D, 1, 1, 5'd9, 64'h4000, 32'h1c00_0028), 1, 0, '0, 1, 0); #1;
        step(); b_drive(0, '0, 0, 1, 64'h8000_0001_0000_0000, 1, 0); #1;
        check("t5_d_final", b_ws_bus[95:32], 64'h8000_0001_0000_0000);
        step(); b_drive(1, mk64(T_B, 1, 1, 5'd9, 64'h4007, 32'h1c00_002c), 1, 0, '0, 1, 0); #1;
        step(); b_drive(0, '0, 0, 1, 64'h80FF_0000_0000_0000, 1, 0); #1;
        check("t5_b7_final", b_ws_bus[95:32], 64'hFFFF_FFFF_FFFF_FF80);
        step(); b_drive(0, '0, 0, 0, '0, 1, 0); #1;

        // async reset while an instruction waits and a discard is pending
        step(); a_drive(1, mk32(T_W, 1, 1, 5'd10, 32'h5000, 32'h1c00_0030), 1, 0, '0, 1, 0); #1;
        step(); a_drive(0, '0, 0, 0, '0, 1, 1); #1;
        step(); a_drive(1, mk32(T_W, 1, 1, 5'd11, 32'h5004, 32'h1c00_0034), 1, 0, '0, 1, 0); #1;
        step(); a_drive(0, '0, 0, 0, '0, 1, 0); #1;
        check("t6_pre_allowin", 64'(a_allowin), 64'd0);
        check("t6_pre_cncl", 64'(u32.cncl_cnt), 64'd1);
        resetn = 1'b0; #1;
        check("t6_rst_valid", 64'(a_ws_valid), 64'd0);
        check("t6_rst_allowin", 64'(a_allowin), 64'd1);
        check("t6_rst_cncl", 64'(u32.cncl_cnt), 64'd0);
        check("t6_rst_bus", 64'(a_ws_bus), 64'd0);
        step(); resetn = 1'b1; #1;
        step(); #1;
        check("t6_post_allowin", 64'(a_allowin), 64'd1);
        check("t6_post_valid_o", 64'(a_valid_o), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stage_resp.md
Name: mem_stage_resp

Overview:
- Parametrised memory-access pipeline stage between EX and WB. Successor to the fixed 32-bit MEM stage.
- Data memory replies on a split request/response interface (data_ok), not in a fixed cycle, so the stage stalls until the response arrives.
- Holds returned data while WB back-pressures.
- Discards responses that belong to flushed instructions.
- Aligns and sign- or zero-extends load data for an XLEN of 32 or 64.

Parameters:
- DATA_W, 32, datapath/XLEN width (32 or 64 only).
- LDT_W, 7, one-hot load-type width {ld_b, ld_bu, ld_h, ld_hu, ld_w, ld_wu, ld_d}.
- ES_BUS_W, LDT_W+1+1+5+DATA_W+32, EX→MEM bus width.
- WS_BUS_W, 1+5+DATA_W+32, MEM→WB bus width.
- CNCL_W, 2, width of the discard counter.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- es_to_ms_valid  in  1  EX holds a valid instruction
- es_to_ms_bus  in  ES_BUS_W  {ld_type, res_from_mem, gr_we, dest[4:0], alu_result, pc}
- es_mem_req  in  1  qualifies es_to_ms_bus: EX's data request for this instruction was accepted (addr_ok)
- ms_allowin  out  1  MEM can accept from EX
- ms_to_ws_valid  out  1  MEM result valid to WB
- ms_to_ws_bus  out  WS_BUS_W  {gr_we, dest, final_result, pc}
- ws_allowin  in  1  WB can accept
- data_sram_data_ok  in  1  read/write response valid this cycle
- data_sram_rdata  in  DATA_W  response data
- flush  in  1  exception/ertn flush; kills MEM content
- ms_valid_o  out  1  raw stage valid (hazard logic)

Behaviour:
- Reset (async, resetn=0):
  - ms_valid=0; state=EMPTY; cncl_cnt=0; bus register and data buffer=0.
  - Outputs: ms_to_ws_valid=0, ms_allowin=1, ms_to_ws_bus=0, ms_valid_o=0.
- Handshake:
  - ms_allowin = !ms_valid | (ms_ready_go & ws_allowin).
  - ms_to_ws_valid = ms_valid & ms_ready_go & !flush.
  - Latch the bus when es_to_ms_valid & ms_allowin & !flush.
  - On latch, state goes to WAIT if es_mem_req=1, else READY.
  - es_mem_req marks an outstanding response.
- States:
  - EMPTY: no valid instruction.
  - WAIT: ms_ready_go = data_ok & (cncl_cnt==0).
    - If data_ok arrives, cncl_cnt==0 and ws_allowin=1: result forwarded this cycle.
    - If the next instruction is latched in the same cycle, go to WAIT or READY per its es_mem_req; otherwise go to EMPTY.
    - If data_ok arrives and ws_allowin=0: capture rdata into the buffer and go to HOLD.
  - HOLD: ms_ready_go=1; result uses the buffered data.
  - READY: no memory request outstanding; ms_ready_go=1.
  - HOLD and READY go to the next state when ms_to_ws_valid & ws_allowin.
- Flush:
  - ms_valid cleared next edge; state=EMPTY.
  - If state was WAIT and no data_ok arrives this cycle, cncl_cnt increments.
  - flush & es_to_ms_valid: nothing latched.
- Discard:
  - Responses return in order.
  - While cncl_cnt>0, every data_ok decrements cncl_cnt and is ignored.
  - If cncl_cnt>0 and an increment and a decrement coincide, cncl_cnt holds.
  - cncl_cnt saturates at 2^CNCL_W-1; reaching the maximum is an error, and an assertion is fired in simulation.
- Load extract:
  - Byte offset = alu_result[log2(DATA_W/8)-1:0]. Select the addressed byte, half or word.
  - b/h/w sign-extend; bu/hu/wu zero-extend; d passes the full 64 bits.
  - With DATA_W=32: wu and d behave as w.
  - Misaligned offsets never reach MEM (trapped in EX); the result for them is don't-care.
- final_result = res_from_mem ? extracted data : alu_result.
- Stores: res_from_mem=0, gr_we=0. They still wait for data_ok when es_mem_req=1.

Test Plan:
- Load with a 3-cycle response: ld_b, alu_result=0x1003, data_ok at cycle 3 with rdata=0x80FF_1234, ws_allowin=1 → ms_to_ws_valid only in cycle 3; final_result=0xFFFF_FF80. ms_allowin=0 in cycles 1–2.
- HOLD: ld_hu, offset 2, rdata=0xBEEF_0001 with data_ok while ws_allowin=0 for 2 cycles → result 0x0000_BEEF presented for 3 cycles. Data stays stable after data_ok drops.
- Flush in WAIT: flush during cycle 1 of an outstanding ld_w, then a new ld_w is accepted → the first data_ok (rdata=0xDEAD) is discarded and cncl_cnt returns to 0. The second data_ok (0x1234) is written back.
- Non-memory instruction: add with alu_result=0x55, es_mem_req=0 → ms_to_ws_valid the cycle after acceptance; final_result=0x55.
- DATA_W=64: ld_w at offset 4, rdata=0x8000_0001_0000_0000 → 0xFFFF_FFFF_8000_0001. ld_wu at offset 4 → 0x0000_0000_8000_0001.
- Async reset mid-WAIT: resetn low between clock edges → ms_to_ws_valid=0 immediately; ms_allowin=1; cncl_cnt=0.
